// File: rtl/fill_data_array.sv
// Cache data array with byte-masked CPU writes, a registered write-first read port
// and a line-fill engine that assembles memory beats into a full line before committing it.
module fill_data_array #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8,
  parameter int BEAT  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_index,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_index,
  input  logic [WIDTH/8-1:0]       wr_bmask,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_stall,
  input  logic                     fill_start,
  input  logic [$clog2(DEPTH)-1:0] fill_index,
  input  logic                     fill_beat_valid,
  input  logic [BEAT-1:0]          fill_beat_data,
  output logic                     fill_busy,
  output logic                     fill_done
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int NBEATS = WIDTH / BEAT;
  localparam int BYTES  = WIDTH / 8;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic [IDX_W-1:0]   fill_idx_r;
  logic [WIDTH-1:0]   line_buf_r;
  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic               last_beat_s;
  logic               commit_s;
  logic               wr_accept_s;
  logic [WIDTH-1:0]   merged_s;
  logic [WIDTH-1:0]   rd_line_s;

  function automatic logic [WIDTH-1:0] merge_bytes(
    input logic [WIDTH-1:0] old_line,
    input logic [WIDTH-1:0] new_line,
    input logic [BYTES-1:0] mask
  );
    logic [WIDTH-1:0] res;
    res = old_line;
    for (int i = 0; i < BYTES; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_line[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_line[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign last_beat_s = (beat_cnt_r == CNT_W'(NBEATS - 1));
  assign commit_s    = (state_r == COMMIT);
  assign wr_accept_s = wr_en && !wr_stall;

  // Fill FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Fill FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (fill_start) begin
          next_state_s = FILL;
        end else begin
          next_state_s = IDLE;
        end
      end
      FILL: begin
        if (fill_beat_valid && last_beat_s) begin
          next_state_s = COMMIT;
        end else begin
          next_state_s = FILL;
        end
      end
      COMMIT:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Fill FSM outputs, decoded from the state register only
  always_comb begin
    fill_busy = 1'b0;
    fill_done = 1'b0;
    wr_stall  = 1'b0;
    case (state_r)
      IDLE: begin
        fill_busy = 1'b0;
      end
      FILL: begin
        fill_busy = 1'b1;
      end
      COMMIT: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
        wr_stall  = 1'b1;
      end
      default: begin
        fill_busy = 1'b0;
      end
    endcase
  end

  // Fill datapath: latch target line and collect beats into the line buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_r <= '0;
      fill_idx_r <= '0;
      line_buf_r <= '0;
    end else if (state_r == IDLE && fill_start) begin
      fill_idx_r <= fill_index;
      beat_cnt_r <= '0;
    end else if (state_r == FILL && fill_beat_valid) begin
      line_buf_r[BEAT*beat_cnt_r +: BEAT] <= fill_beat_data;
      beat_cnt_r <= beat_cnt_r + CNT_W'(1);
    end
  end

  // Post-write line values for the CPU merge and for write-first reads
  always_comb begin
    merged_s  = merge_bytes(mem_r[wr_index], wr_data, wr_bmask);
    rd_line_s = mem_r[rd_index];
    if (commit_s && rd_index == fill_idx_r) begin
      rd_line_s = line_buf_r;
    end else if (wr_accept_s && wr_index == rd_index) begin
      rd_line_s = merged_s;
    end else begin
      rd_line_s = mem_r[rd_index];
    end
  end

  // Line store: a commit takes priority and the CPU write port is stalled during it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (commit_s) begin
      mem_r[fill_idx_r] <= line_buf_r;
    end else if (wr_accept_s) begin
      mem_r[wr_index] <= merged_s;
    end
  end

  // Registered read port; data holds when no read is requested
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_line_s;
      end
    end
  end

endmodule
